mul_border_ctrl: RTL and testbench

- Job sequencer for one unary-rate border multiplier lane (sobol8-based, rate-coded).
- Accepts an operand pair over a valid/ready handshake and clears the multiplier's sobol generators.
- Runs the multiplier for exactly 2^CYCLE_LOG cycles, counts its output ones, and returns the count as the binary product over a second valid/ready handshake.
- Sits between the systolic border scheduler and the multiplier instance, one controller per lane.

---
 rtl/mul_ctrl_pkg.sv | 24 ++
 rtl/mul_border_ctrl_popcnt_acc.sv | 45 ++++
 rtl/mul_border_ctrl.sv | 127 ++++++++++++
 tb/tb_mul_border_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// ============================================================================
// Module      : mul_ctrl_pkg
// Description : Shared state encoding and run-length helper for the border
//               multiplier job sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mul_ctrl_state_t;

  function automatic int unsigned run_len(input int unsigned cycle_log);
    return 32'd1 << cycle_log;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_border_ctrl_popcnt_acc.sv
// ============================================================================
// Module      : popcnt_acc
// Description : Sample counter plus ones accumulator with synchronous clear
//               and a terminal-count flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module popcnt_acc
  import mul_ctrl_pkg::*;
#(
  parameter int CYCLE_LOG = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bit_in,
  input  logic [CYCLE_LOG-1:0] term,
  output logic [CYCLE_LOG-1:0] count,
  output logic [CYCLE_LOG:0]   acc,
  output logic [CYCLE_LOG:0]   acc_next,
  output logic                 last
);

  // acc_next already includes the current sample, so the final one is not lost
  assign acc_next = acc + {{CYCLE_LOG{1'b0}}, bit_in};
  assign last     = en && (count == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
    end else if (clr) begin
      count <= '0;
      acc   <= '0;
    end else if (en) begin
      count <= count + CYCLE_LOG'(1);
      acc   <= acc_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_border_ctrl.sv
// ============================================================================
// Module      : mul_border_ctrl
// Description : Job sequencer for one rate-coded border multiplier lane.
//               Optional macro MUL_BORDER_CTRL_EARLY_TERM_EN adds i_len.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mul_border_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CYCLE_LOG = WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-2:0]     i_data_i,
  input  logic [WIDTH-2:0]     i_data_w,
`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
  input  logic [CYCLE_LOG-1:0] i_len,
`endif
  output logic                 mul_clr_n,
  output logic [WIDTH-2:0]     mul_data_i,
  output logic [WIDTH-2:0]     mul_data_w,
  input  logic                 mul_bit,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CYCLE_LOG:0]   o_prod,
  output logic                 o_busy
);

  localparam logic [CYCLE_LOG-1:0] LAST_IDX = CYCLE_LOG'(run_len(CYCLE_LOG) - 1);

  mul_ctrl_state_t      state;
  mul_ctrl_state_t      state_next;
  logic                 accept;
  logic [CYCLE_LOG-1:0] term;
  logic [CYCLE_LOG-1:0] count;
  logic [CYCLE_LOG:0]   acc;
  logic [CYCLE_LOG:0]   acc_next;
  logic                 last;

  assign accept = i_valid && o_ready;

`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
  logic [CYCLE_LOG-1:0] len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= LAST_IDX;
    end else if (accept) begin
      len_q <= i_len;
    end
  end

  assign term = len_q;
`else
  assign term = LAST_IDX;
`endif

  popcnt_acc #(
    .CYCLE_LOG(CYCLE_LOG)
  ) u_popcnt_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == CLR),
    .en       (state == RUN),
    .bit_in   (mul_bit),
    .term     (term),
    .count    (count),
    .acc      (acc),
    .acc_next (acc_next),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_busy     = (state != IDLE);
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = CLR;
      end
      CLR:  state_next = RUN;
      RUN:  if (last) state_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear is registered so sobol index 0 lands exactly on the first RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_clr_n  <= 1'b0;
      mul_data_i <= '0;
      mul_data_w <= '0;
      o_prod     <= '0;
    end else begin
      mul_clr_n <= (state_next == RUN);
      if (accept) begin
        mul_data_i <= i_data_i;
        mul_data_w <= i_data_w;
      end
      if (state == RUN && last) begin
        o_prod <= acc_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_border_ctrl.sv
// ============================================================================
// Module      : tb_mul_border_ctrl
// Description : Self-checking bench with a behavioural sobol border multiplier.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mul_border_ctrl;
  import mul_ctrl_pkg::*;

  localparam int WIDTH     = 8;
  localparam int CYCLE_LOG = WIDTH - 1;
  localparam int DW        = WIDTH - 1;
  localparam int RUN_LEN   = 1 << CYCLE_LOG;
  localparam int L_DEF     = RUN_LEN - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [DW-1:0]        i_data_i;
  logic [DW-1:0]        i_data_w;
  logic                 mul_clr_n;
  logic [DW-1:0]        mul_data_i;
  logic [DW-1:0]        mul_data_w;
  logic                 mul_bit;
  logic                 o_valid;
  logic                 i_ready;
  logic [CYCLE_LOG:0]   o_prod;
  logic                 o_busy;
`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
  logic [CYCLE_LOG-1:0] i_len;
`endif

  mul_border_ctrl #(
    .WIDTH(WIDTH),
    .CYCLE_LOG(CYCLE_LOG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_i   (i_data_i),
    .i_data_w   (i_data_w),
`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
    .i_len      (i_len),
`endif
    .mul_clr_n  (mul_clr_n),
    .mul_data_i (mul_data_i),
    .mul_data_w (mul_data_w),
    .mul_bit    (mul_bit),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_prod     (o_prod),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Border multiplier: input stream from a van der Corput sequence; the
  // weight sequence only advances on input ones; registered output.
  function automatic logic [DW-1:0] brev(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < DW; b++) r[b] = x[DW-1-b];
    return r;
  endfunction

  logic          m_rst_n;
  logic [DW-1:0] idx1;
  logic [DW-1:0] idx2;
  logic          in_b;
  logic          w_b;

  assign m_rst_n = rst_n & mul_clr_n;
  assign in_b    = brev(idx1) < mul_data_i;
  assign w_b     = brev(idx2) < mul_data_w;

  always_ff @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      idx1    <= '0;
      idx2    <= '0;
      mul_bit <= 1'b0;
    end else begin
      mul_bit <= in_b & w_b;
      idx1    <= idx1 + DW'(1);
      if (in_b) idx2 <= idx2 + DW'(1);
    end
  end

  // The first RUN sample is the multiplier's reset output, so len+1 samples
  // carry len real products.
  function automatic int ref_prod(input int i, input int w, input int len);
    int cnt;
    int j;
    bit a;
    cnt = 0;
    j   = 0;
    for (int k = 0; k < len; k++) begin
      a = int'(brev(DW'(k))) < i;
      if (a && (int'(brev(DW'(j))) < w)) cnt++;
      if (a) j++;
    end
    return cnt;
  endfunction

  typedef struct {
    int i;
    int w;
    int len;
    int hold;
    int exp;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int n;
    int lat;
    int runs;
    int bad;
    int held;
    int e;
    n = 0;
    while (!o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_job", int'(o_ready), 1);
    i_data_i = DW'(v.i);
    i_data_w = DW'(v.w);
`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
    i_len = CYCLE_LOG'(v.len);
`endif
    i_valid = 1'b1;
    exp_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    // Keep requesting with different operands while busy; must be ignored.
    i_data_i = ~DW'(v.i);
    i_data_w = ~DW'(v.w);
    i_ready  = (v.hold == 0);
    check("busy_after_accept", int'(o_busy), 1);
    lat  = 1;
    runs = 0;
    while (1) begin
      if (mul_clr_n) runs++;
      if (o_valid || lat >= 400) break;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, v.len + 3);
    check("run_cycles", runs, v.len + 1);
    if (v.hold > 0) begin
      held = int'(o_prod);
      bad  = 0;
      repeat (v.hold) begin
        i_data_i = DW'($urandom);
        @(negedge clk);
        if (int'(o_prod) != held || !o_valid || o_ready || mul_clr_n) bad++;
      end
      check("hold_stable", bad, 0);
      check("ops_latched", int'(mul_data_i), v.i);
      i_ready = 1'b1;
    end
    i_valid = 1'b0;
    e = exp_q.pop_front();
    check("prod", int'(o_prod), e);
    @(negedge clk);
    check("valid_dropped", int'(o_valid), 0);
    check("ready_after_release", int'(o_ready), 1);
    check("prod_retained", int'(o_prod), e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data_i = '0;
    i_data_w = '0;
`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
    i_len = CYCLE_LOG'(L_DEF);
`endif

    vecs.push_back('{64, 64, L_DEF, 0, 32});
    vecs.push_back('{127, 127, L_DEF, 0, 127});
    vecs.push_back('{0, 127, L_DEF, 0, 0});
    vecs.push_back('{127, 0, L_DEF, 0, 0});
    vecs.push_back('{64, 64, L_DEF, 50, 32});
    vecs.push_back('{100, 37, L_DEF, 0, ref_prod(100, 37, L_DEF)});
    vecs.push_back('{1, 127, L_DEF, 3, ref_prod(1, 127, L_DEF)});
`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
    vecs.push_back('{127, 127, 63, 0, 63});
    vecs.push_back('{90, 70, 20, 0, ref_prod(90, 70, 20)});
`endif

    repeat (3) @(negedge clk);
    check("rst_ready", int'(o_ready), 1);
    check("rst_valid", int'(o_valid), 0);
    check("rst_prod", int'(o_prod), 0);
    check("rst_clr_n", int'(mul_clr_n), 0);
    check("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) run_job(vecs[k]);

    // Reset pulse in the middle of RUN drops the job.
    i_data_i = DW'(64);
    i_data_w = DW'(64);
`ifdef MUL_BORDER_CTRL_EARLY_TERM_EN
    i_len = CYCLE_LOG'(L_DEF);
`endif
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (61) @(negedge clk);
    check("mid_run_busy", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", int'(o_ready), 1);
    check("async_rst_valid", int'(o_valid), 0);
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_clr_n", int'(mul_clr_n), 0);
    check("async_rst_data", int'(mul_data_i), 0);
    check("async_rst_prod", int'(o_prod), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (140) begin
      @(negedge clk);
      if (o_valid || o_busy) cnt++;
    end
    check("no_valid_after_drop", cnt, 0);
    run_job('{64, 64, L_DEF, 0, 32});

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
